pipelined_cla_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor. Generalises the fixed 8-bit combinational CLA to WIDTH bits, split into GROUP-bit lookahead groups with one register stage per group. Adds a valid/ready stream handshake with full backpressure, an add/subtract mode and signed-overflow/zero flags. Sits between operand sources (switch/UART front ends, datapath registers) and result consumers (7-segment display driver, accumulator logic).

---
 rtl/pipelined_cla_pkg.sv | 12 +
 rtl/pipelined_cla_adder_cla_group.sv | 45 ++++
 rtl/pipelined_cla_adder.sv | 144 ++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_cla_pkg.sv
// Shared elaboration helpers for the pipelined carry-lookahead adder.
package pipelined_cla_pkg;

  function automatic int num_stages(input int width, input int group);
    return width / group;
  endfunction

  function automatic bit width_fits(input int width, input int group);
    return (group > 0) && (width >= group) && ((width % group) == 0);
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla_group.sv
// Combinational GROUP-bit carry-lookahead block: per-bit carries, group generate/propagate,
// carry out and the carry into the group's MSB (used for signed overflow).
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout,
  output logic             msb_cin,
  output logic             gg,
  output logic             gp
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP-1:0] carry;

  assign g = a & b;
  assign p = a ^ b;

  // Carry into bit k expressed purely from g/p/cin, so each bit flattens to sum-of-products.
  function automatic logic carry_into(input int k, input logic [GROUP-1:0] g_v,
                                      input logic [GROUP-1:0] p_v, input logic c0);
    logic c;
    c = c0;
    for (int j = 0; j < GROUP; j++) begin
      if (j < k) c = g_v[j] | (p_v[j] & c);
    end
    return c;
  endfunction

  genvar gi;
  for (gi = 0; gi < GROUP; gi++) begin : g_bit
    assign carry[gi] = carry_into(gi, g, p, cin);
  end

  assign gg      = carry_into(GROUP, g, p, 1'b0);
  assign gp      = &p;
  assign cout    = gg | (gp & cin);
  assign msb_cin = carry[GROUP-1];
  assign sum     = p ^ carry;

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor: one lookahead group per register stage, skewed operands,
// valid/ready handshake with a single global advance so a stalled output freezes every stage.
module pipelined_cla_adder
  import pipelined_cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int N = num_stages(WIDTH, GROUP);

  if (!width_fits(WIDTH, GROUP)) begin : g_bad_width
    $error("pipelined_cla_adder: WIDTH must be a nonzero multiple of GROUP");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign b_eff    = b ^ {WIDTH{sub}};
  assign cin_eff  = c_in ^ sub;
  assign in_ready = !out_valid || out_ready;
  assign advance  = in_ready;

  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_stage
    localparam int SUM_W = (gi + 1) * GROUP;

    logic             valid_q;
    logic             carry_q;
    logic [SUM_W-1:0] sum_q;
    logic             valid_d;
    logic [SUM_W-1:0] sum_d;
    logic [GROUP-1:0] a_grp;
    logic [GROUP-1:0] b_grp;
    logic             c_grp;
    logic [GROUP-1:0] sum_grp;
    logic             cout_grp;
    logic             msb_cin_grp;
    logic             gg_grp;
    logic             gp_grp;
    logic             unused_taps;

    if (gi == 0) begin : g_head
      assign valid_d = in_valid;
      assign a_grp   = a[GROUP-1:0];
      assign b_grp   = b_eff[GROUP-1:0];
      assign c_grp   = cin_eff;
      assign sum_d   = sum_grp;
    end else begin : g_body
      assign valid_d = g_stage[gi-1].valid_q;
      assign a_grp   = g_stage[gi-1].g_ops.opa_q[GROUP-1:0];
      assign b_grp   = g_stage[gi-1].g_ops.opb_q[GROUP-1:0];
      assign c_grp   = g_stage[gi-1].carry_q;
      assign sum_d   = {sum_grp, g_stage[gi-1].sum_q};
    end

    cla_group #(.GROUP(GROUP)) u_cla (
      .a       (a_grp),
      .b       (b_grp),
      .cin     (c_grp),
      .sum     (sum_grp),
      .cout    (cout_grp),
      .msb_cin (msb_cin_grp),
      .gg      (gg_grp),
      .gp      (gp_grp)
    );

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (advance) begin
        valid_q <= valid_d;
        carry_q <= cout_grp;
        sum_q   <= sum_d;
      end
    end

    // Operand bits not yet consumed ride along with their operation; the last stage has none left.
    if (gi < N - 1) begin : g_ops
      localparam int OP_W = WIDTH - SUM_W;
      logic [OP_W-1:0] opa_q, opb_q, opa_d, opb_d;

      if (gi == 0) begin : g_src
        assign opa_d = a[WIDTH-1:GROUP];
        assign opb_d = b_eff[WIDTH-1:GROUP];
      end else begin : g_src
        assign opa_d = g_stage[gi-1].g_ops.opa_q[OP_W+GROUP-1:GROUP];
        assign opb_d = g_stage[gi-1].g_ops.opb_q[OP_W+GROUP-1:GROUP];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          opa_q <= '0;
          opb_q <= '0;
        end else if (advance) begin
          opa_q <= opa_d;
          opb_q <= opb_d;
        end
      end

      assign unused_taps = gg_grp ^ gp_grp ^ msb_cin_grp;
    end else begin : g_tail
      logic ovf_q;
      logic zero_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (advance) begin
          ovf_q  <= msb_cin_grp ^ cout_grp;
          zero_q <= (sum_d == '0);
        end
      end

      assign unused_taps = gg_grp ^ gp_grp;
    end
  end

  assign out_valid = g_stage[N-1].valid_q;
  assign s         = g_stage[N-1].sum_q;
  assign c_out     = g_stage[N-1].carry_q;
  assign overflow  = g_stage[N-1].g_tail.ovf_q;
  assign zero      = g_stage[N-1].g_tail.zero_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder: directed vectors, backpressure, random stream, reset.
module tb_pipelined_cla_adder;

  localparam int W = 16;
  localparam int G = 4;
  localparam int N = W / G;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         ov;
    logic         z;
  } res_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] s;
  logic         c_out;
  logic         overflow;
  logic         zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(W), .GROUP(G)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .c_out     (c_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  // Reference: plain integer arithmetic, signed range test for overflow, borrow sense for sub.
  function automatic res_t ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic ci, input logic sb);
    longint ux, uy, sx, sy, ur, sr;
    res_t   r;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!sb) begin
      ur   = ux + uy + longint'(ci);
      sr   = sx + sy + longint'(ci);
      r.c  = (ur >= (longint'(1) << W));
    end else begin
      ur   = ux - uy - longint'(ci);
      sr   = sx - sy - longint'(ci);
      r.c  = (ur >= 0);
    end
    r.s  = ur[W-1:0];
    r.ov = (sr > ((longint'(1) << (W - 1)) - 1)) || (sr < -(longint'(1) << (W - 1)));
    r.z  = (r.s == '0);
    return r;
  endfunction

  function automatic res_t dut_res();
    return {s, c_out, overflow, zero};
  endfunction

  task automatic rand_op();
    a    = W'($urandom);
    b    = W'($urandom);
    c_in = 1'($urandom);
    sub  = 1'($urandom);
    if ($urandom_range(0, 7) == 0) a = {W{1'b1}};
    if ($urandom_range(0, 7) == 0) b = {1'b1, {(W-1){1'b0}}};
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, s, c_out, overflow, zero} !== '0)
      $display("FAIL reset_outputs: got v=%b s=%h c=%b ov=%b z=%b, expected all zero",
               out_valid, s, c_out, overflow, zero);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
    end
    if ({out_valid, s, c_out, overflow, zero} !== '0) errors++;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] va[6] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h0010};
    logic [W-1:0] vb[6] = '{16'h0001, 16'h0001, 16'h0001, 16'h8000, 16'h0007, 16'h0001};
    logic [5:0]   vci   = 6'b100000;
    logic [5:0]   vsb   = 6'b110000;
    res_t         vexp[6] = '{'{16'h0100, 1'b0, 1'b0, 1'b0}, '{16'h0000, 1'b1, 1'b0, 1'b1},
                              '{16'h8000, 1'b0, 1'b1, 1'b0}, '{16'h0000, 1'b1, 1'b1, 1'b1},
                              '{16'hFFFE, 1'b0, 1'b0, 1'b0}, '{16'h000E, 1'b1, 1'b0, 1'b0}};
    res_t got;
    int   cyc;
    for (int i = 0; i < 6; i++) begin
      a = va[i]; b = vb[i]; c_in = vci[i]; sub = vsb[i];
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      cyc = 1;
      @(negedge clk);
      while (out_valid !== 1'b1 && cyc < N + 4) begin
        @(negedge clk);
        cyc++;
      end
      got = dut_res();
      $display("directed %0d: a=%h b=%h cin=%b sub=%b -> s=%h c=%b ov=%b z=%b latency=%0d",
               i, va[i], vb[i], vci[i], vsb[i], got.s, got.c, got.ov, got.z, cyc);
      checks++;
      if (cyc != N) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d cycles, expected %0d", i, cyc, N);
      end
      checks++;
      if (got !== vexp[i]) begin
        errors++;
        $display("FAIL directed_result[%0d]: got s=%h c=%b ov=%b z=%b, expected s=%h c=%b ov=%b z=%b",
                 i, got.s, got.c, got.ov, got.z, vexp[i].s, vexp[i].c, vexp[i].ov, vexp[i].z);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    res_t         exp_q[$];
    res_t         got, want;
    int           issued = 0, got_n = 0, stall_left = 3;
    bit           started = 0, have_held = 0, accepted;
    logic [W-1:0] held_s = '0;
    rand_op();
    for (int cyc = 0; cyc < 80 && got_n < 6; cyc++) begin
      in_valid = (issued < 6);
      if (out_valid === 1'b1) started = 1;
      out_ready = !(started && stall_left > 0);
      @(negedge clk);
      if (!out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_in_ready_stall: got %b, expected 0", in_ready);
        end
        stall_left--;
      end
      if (out_valid === 1'b1 && have_held) begin
        checks++;
        if (s !== held_s) begin
          errors++;
          $display("FAIL b2b_stall_stable: got s=%h, expected %h", s, held_s);
        end
      end
      have_held = (out_valid === 1'b1) && !out_ready;
      held_s    = s;
      accepted  = in_valid && (in_ready === 1'b1);
      if (accepted) begin
        exp_q.push_back(ref_op(a, b, c_in, sub));
        issued++;
      end
      if (out_valid === 1'b1 && out_ready) begin
        got = dut_res();
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra_result: got s=%h with nothing outstanding", got.s);
        end else begin
          want = exp_q.pop_front();
          $display("b2b %0d: s=%h c=%b ov=%b z=%b", got_n, got.s, got.c, got.ov, got.z);
          if (got !== want) begin
            errors++;
            $display("FAIL b2b_result[%0d]: got s=%h c=%b ov=%b z=%b, expected s=%h c=%b ov=%b z=%b",
                     got_n, got.s, got.c, got.ov, got.z, want.s, want.c, want.ov, want.z);
          end
        end
        got_n++;
      end
      @(posedge clk);
      #1;
      if (accepted) rand_op();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got_n != 6 || stall_left != 0) begin
      errors++;
      $display("FAIL b2b_count: got %0d results (stall cycles left %0d), expected 6 (0)", got_n, stall_left);
    end
  endtask

  task automatic test_random();
    res_t exp_q[$];
    res_t got, want;
    int   n_out = 0, drain;
    bit   accepted;
    rand_op();
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      accepted = in_valid && (in_ready === 1'b1);
      if (accepted) exp_q.push_back(ref_op(a, b, c_in, sub));
      if (out_valid === 1'b1 && out_ready) begin
        got = dut_res();
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra_result: got s=%h with nothing outstanding", got.s);
        end else begin
          want = exp_q.pop_front();
          $display("rand %0d: s=%h c=%b ov=%b z=%b", n_out, got.s, got.c, got.ov, got.z);
          if (got !== want) begin
            errors++;
            $display("FAIL rand_result[%0d]: got s=%h c=%b ov=%b z=%b, expected s=%h c=%b ov=%b z=%b",
                     n_out, got.s, got.c, got.ov, got.z, want.s, want.c, want.ov, want.z);
          end
        end
        n_out++;
      end
      @(posedge clk);
      #1;
      if (accepted) rand_op();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain = 0;
    while (exp_q.size() > 0 && drain < 4 * N) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        got  = dut_res();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL rand_drain: got s=%h c=%b ov=%b z=%b, expected s=%h c=%b ov=%b z=%b",
                   got.s, got.c, got.ov, got.z, want.s, want.c, want.ov, want.z);
        end
      end
      @(posedge clk);
      #1;
      drain++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_drain_timeout: got %0d results still pending, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    res_t want, got;
    int   cyc;
    bit   stale = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_op();
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_precondition: got out_valid=%b, expected 1", out_valid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, s, c_out, overflow, zero} !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_outputs: got v=%b s=%h c=%b ov=%b z=%b rdy=%b, expected zeros and rdy=1",
               out_valid, s, c_out, overflow, zero, in_ready);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale = 1;
    end
    checks++;
    if (stale) begin
      errors++;
      $display("FAIL midreset_stale: got out_valid=1 after reset, expected 0");
    end
    @(posedge clk);
    #1;
    rand_op();
    want = ref_op(a, b, c_in, sub);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc = 1;
    @(negedge clk);
    while (out_valid !== 1'b1 && cyc < N + 4) begin
      @(negedge clk);
      cyc++;
    end
    got = dut_res();
    $display("post-reset op: s=%h c=%b ov=%b z=%b latency=%0d", got.s, got.c, got.ov, got.z, cyc);
    checks++;
    if (cyc != N || got !== want) begin
      errors++;
      $display("FAIL midreset_new_op: got s=%h c=%b ov=%b z=%b lat=%0d, expected s=%h c=%b ov=%b z=%b lat=%0d",
               got.s, got.c, got.ov, got.z, cyc, want.s, want.c, want.ov, want.z, N);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
